// File: rtl/vga_timing.sv
// VGA raster timing generator.
// Free-running pixel/line counters with sync and blanking flags decoded from the
// next-state counts, so every flag lines up with the count shown in the same
// cycle. A frame-start pulse and a completed-frame counter mark each wrap to (0,0).
module vga_timing #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        en,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_BLK      = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_BLK      = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        frame_start_q;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        h_last, v_last, frame_wrap;

  // Next counts and the flags they imply; vertical flags only move when the line wraps
  always_comb begin
    h_last      = (hcount_q == H_LAST);
    v_last      = (vcount_q == V_LAST);
    frame_wrap  = h_last && v_last;
    hcount_d    = h_last ? 11'd0 : hcount_q + 11'd1;
    vcount_d    = vcount_q;
    if (h_last) begin
      vcount_d = v_last ? 11'd0 : vcount_q + 11'd1;
    end
    hblnk_d     = (hcount_d >= H_BLK);
    hsync_d     = (hcount_d >= H_SYNC_BEG) && (hcount_d < H_SYNC_END);
    vblnk_d     = (vcount_d >= V_BLK);
    vsync_d     = (vcount_d >= V_SYNC_BEG) && (vcount_d < V_SYNC_END);
    frame_cnt_d = frame_cnt_q + 16'd1;
  end

  // Registered counters and flags; everything freezes while en is low
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q      <= '0;
      vcount_q      <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      frame_start_q <= en && frame_wrap;
      if (en) begin
        hcount_q <= hcount_d;
        vcount_q <= vcount_d;
        hsync_q  <= hsync_d;
        vsync_q  <= vsync_d;
        hblnk_q  <= hblnk_d;
        vblnk_q  <= vblnk_d;
        if (frame_wrap) begin
          frame_cnt_q <= frame_cnt_d;
        end
      end
    end
  end

  assign hcount_out  = hcount_q;
  assign vcount_out  = vcount_q;
  assign hsync_out   = hsync_q;
  assign vsync_out   = vsync_q;
  assign hblnk_out   = hblnk_q;
  assign vblnk_out   = vblnk_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing using a shrunken raster so whole frames fit in a
// short run: H = 16/2/4/3 (total 25, hsync 18..21), V = 8/1/2/2 (total 13,
// vsync 9..10), i.e. 325 cycles per frame.
module tb_vga_timing;

  localparam int HT = 25;
  localparam int VT = 13;

  logic        pclk;
  logic        rst_n;
  logic        en;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic        frame_start;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit sb_on    = 1'b0;

  // Reference raster position, independent of the DUT
  int m_h = 0, m_v = 0;
  bit m_fs = 1'b0;

  vga_timing #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2)
  ) dut (
    .pclk        (pclk),
    .rst_n       (rst_n),
    .en          (en),
    .hcount_out  (hcount_out),
    .vcount_out  (vcount_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .hblnk_out   (hblnk_out),
    .vblnk_out   (vblnk_out),
    .frame_start (frame_start),
    .frame_cnt   (frame_cnt)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] decode(input int h, input int v);
    logic hs, hb, vs, vb;
    hs = (h >= 18) && (h <= 21);
    hb = (h >= 16);
    vs = (v >= 9) && (v <= 10);
    vb = (v >= 8);
    return {hs, hb, vs, vb};
  endfunction

  // Reference model of the raster position
  always @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      m_h  <= 0;
      m_v  <= 0;
      m_fs <= 1'b0;
    end else if (en) begin
      m_fs <= (m_h == HT - 1) && (m_v == VT - 1);
      if (m_h == HT - 1) begin
        m_h <= 0;
        m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h <= m_h + 1;
      end
    end else begin
      m_fs <= 1'b0;
    end
  end

  // Per-cycle scoreboard: position vs model, flags vs decode of the shown counts
  always @(negedge pclk) begin
    if (sb_on) begin
      check("sb_pos", {9'd0, hcount_out, vcount_out, frame_start},
            {9'd0, 11'(m_h), 11'(m_v), m_fs});
      check("sb_flags", {28'd0, hsync_out, hblnk_out, vsync_out, vblnk_out},
            {28'd0, decode(int'(hcount_out), int'(vcount_out))});
      check("sb_model_flags", {28'd0, hsync_out, hblnk_out, vsync_out, vblnk_out},
            {28'd0, decode(m_h, m_v)});
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_h"},  32'(hcount_out), 32'd0);
    check({tag, "_v"},  32'(vcount_out), 32'd0);
    check({tag, "_hs"}, 32'(hsync_out), 32'd0);
    check({tag, "_vs"}, 32'(vsync_out), 32'd0);
    check({tag, "_hb"}, 32'(hblnk_out), 32'd0);
    check({tag, "_vb"}, 32'(vblnk_out), 32'd0);
    check({tag, "_fs"}, 32'(frame_start), 32'd0);
    check({tag, "_fc"}, 32'(frame_cnt), 32'd0);
  endtask

  // Step until the shown position is (h, v); a blown budget counts as a failure
  task automatic goto_pos(input string tag, input int h, input int v);
    int budget;
    budget = 2 * HT * VT;
    while (!(int'(hcount_out) == h && int'(vcount_out) == v) && budget > 0) begin
      step(1);
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_frame_start(input string tag);
    int budget;
    budget = 2 * HT * VT;
    while (frame_start !== 1'b1 && budget > 0) begin
      step(1);
      budget--;
    end
    if (budget == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int hs_cnt, vs_cnt, vb_cnt, fs_cnt;
    rst_n = 1'b0;
    en    = 1'b0;
    step(3);
    check_all_zero("rst");

    // Reset release with en high: first edge shows hcount 1
    rst_n = 1'b1;
    en    = 1'b1;
    sb_on = 1'b1;
    step(1);
    check("rel_h", 32'(hcount_out), 32'd1);
    check("rel_v", 32'(vcount_out), 32'd0);
    check("rel_fs", 32'(frame_start), 32'd0);

    // Line timing
    step(14);
    check("line_h15", 32'(hcount_out), 32'd15);
    check("line_hb15", 32'(hblnk_out), 32'd0);
    step(1);
    check("line_hb16", 32'(hblnk_out), 32'd1);
    step(1);
    check("line_hs17", 32'(hsync_out), 32'd0);
    step(1);
    check("line_hs18", 32'(hsync_out), 32'd1);
    step(3);
    check("line_hs21", 32'(hsync_out), 32'd1);
    step(1);
    check("line_hs22", 32'(hsync_out), 32'd0);
    step(2);
    check("line_h24", 32'(hcount_out), 32'd24);
    step(1);
    check("line_wrap_h", 32'(hcount_out), 32'd0);
    check("line_wrap_v", 32'(vcount_out), 32'd1);
    check("line_wrap_hb", 32'(hblnk_out), 32'd0);
    hs_cnt = 0;
    for (int i = 0; i < HT; i++) begin
      step(1);
      if (hsync_out) hs_cnt++;
    end
    check("line_hs_width", 32'(hs_cnt), 32'd4);
    check("line_v2", 32'(vcount_out), 32'd2);

    // Frame timing
    wait_frame_start("frame1");
    check("frame1_h", 32'(hcount_out), 32'd0);
    check("frame1_v", 32'(vcount_out), 32'd0);
    check("frame1_fc", 32'(frame_cnt), 32'd1);
    vs_cnt = 0; vb_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < HT * VT; i++) begin
      step(1);
      if (vsync_out) vs_cnt++;
      if (vblnk_out) vb_cnt++;
      if (frame_start) fs_cnt++;
    end
    check("frame_vs_cycles", 32'(vs_cnt), 32'd50);
    check("frame_vb_cycles", 32'(vb_cnt), 32'd125);
    check("frame_fs_pulses", 32'(fs_cnt), 32'd1);
    check("frame2_fs", 32'(frame_start), 32'd1);
    check("frame2_fc", 32'(frame_cnt), 32'd2);

    // Enable stall at hcount 10 of line 0
    goto_pos("stall", 10, 0);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check("stall_h", 32'(hcount_out), 32'd10);
      check("stall_fs", 32'(frame_start), 32'd0);
    end
    check("stall_fc", 32'(frame_cnt), 32'd2);
    en = 1'b1;
    step(1);
    check("stall_resume_h", 32'(hcount_out), 32'd11);

    // Asynchronous reset inside hsync and vsync
    goto_pos("midrst", 19, 9);
    check("midrst_hs_pre", 32'(hsync_out), 32'd1);
    check("midrst_vs_pre", 32'(vsync_out), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    step(2);
    rst_n = 1'b1;
    step(1);
    check("midrst_restart_h", 32'(hcount_out), 32'd1);
    check("midrst_restart_v", 32'(vcount_out), 32'd0);
    check("midrst_restart_fs", 32'(frame_start), 32'd0);

    // Frame counter wrap from 16'hFFFF
    en = 1'b0;
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    step(1);
    check("wrap_pre_fc", 32'(frame_cnt), 32'hFFFF);
    en = 1'b1;
    wait_frame_start("wrap");
    check("wrap_fs", 32'(frame_start), 32'd1);
    check("wrap_fc", 32'(frame_cnt), 32'd0);
    step(1);
    check("wrap_fs_off", 32'(frame_start), 32'd0);

    sb_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, hsync pulse width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 4, vsync pulse width
- V_BP, 23, vertical back porch

REQ-002 Ports SHALL be (name, direction, width, meaning):
- pclk, input, 1, pixel clock; all state changes on its rising edge
- rst_n, input, 1, asynchronous active-low reset
- en, input, 1, advance enable; counters move only when high
- hcount_out, output, 11, current pixel column
- vcount_out, output, 11, current line
- hsync_out, output, 1, horizontal sync, active high
- vsync_out, output, 1, vertical sync, active high
- hblnk_out, output, 1, horizontal blanking
- vblnk_out, output, 1, vertical blanking
- frame_start, output, 1, one-cycle pulse at start of each new frame
- frame_cnt, output, 16, completed-frame counter

REQ-003 Reset SHALL be asynchronous and active-low on rst_n, and all logic SHALL be clocked by the single clock pclk.

Function
REQ-004 Totals SHALL be H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056) and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
REQ-005 When en=1, hcount_out SHALL increment by 1 per pclk cycle.
- At hcount_out=H_TOTAL-1, hcount_out SHALL wrap to 0 and vcount_out SHALL increment.
- At vcount_out=V_TOTAL-1 with hcount_out=H_TOTAL-1, both SHALL wrap to 0.
REQ-006 When en=0, all outputs SHALL hold their values. frame_start SHALL be 0.
REQ-007 hblnk_out SHALL be 1 iff hcount_out >= H_ACTIVE.
REQ-008 hsync_out SHALL be 1 iff H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (840..967).
REQ-009 vblnk_out SHALL be 1 iff vcount_out >= V_ACTIVE.
REQ-010 vsync_out SHALL be 1 iff V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (601..604).
- vsync_out and vblnk_out SHALL change only on the cycle where hcount_out becomes 0.
REQ-011 All outputs SHALL be registered. sync and blank SHALL be decoded from next-state counts, so they correspond to the hcount_out/vcount_out shown in the same cycle (zero skew, zero latency between count and flags).
REQ-012 frame_start SHALL be 1 for exactly one cycle when the outputs wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). It SHALL NOT be asserted on reset release.
REQ-013 frame_cnt SHALL increment by 1 in the same cycle frame_start is asserted. It SHALL wrap from 16'hFFFF to 0 silently.
REQ-014 Counter arithmetic SHALL be 11-bit unsigned. Counts SHALL never reach H_TOTAL or V_TOTAL.

Reset
REQ-015 While rst_n=0, all outputs SHALL be 0 and vsync_out SHALL be 0. This covers hcount_out, vcount_out, both syncs, both blanks, frame_start and frame_cnt.
REQ-016 Reset asserted mid-frame SHALL clear all outputs immediately, without waiting for pclk.
REQ-017 After rst_n rises with en=1, the first rising pclk edge SHALL produce hcount_out=1, vcount_out=0.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Line timing: release reset, en=1, count 1056 cycles -> hblnk_out rises at hcount 800; hsync_out is high for hcount 840..967 (128 cycles); vcount_out becomes 1 at the wrap.
- Frame timing: run 663168 cycles -> frame_start pulses once at (0,0); frame_cnt=1; vblnk_out high on lines 600..627; vsync_out high on lines 601..604 (4x1056 cycles).
- Enable stall: drop en at hcount 500 for 37 cycles -> all outputs frozen at hcount 500; counting resumes at 501; frame_start stays 0.
- Mid-operation reset: assert rst_n=0 at (hcount 900, vcount 602), asynchronous to pclk -> all outputs are 0 immediately; restart from 0; no frame_start pulse.
- Frame counter wrap: preload via 65536 frames (or force) -> frame_cnt goes 16'hFFFF->0 coincident with frame_start.
- Self-check: a scoreboard asserts every cycle that the flags match the REQ-007..REQ-010 decodes of the current counts.
